// File: rtl/spm_sched_if.sv
//==============================================================================
// spm_sched_if: request/response and SPM-side bus of the SPM scheduler. rev 1.0
//==============================================================================
`default_nettype none

interface spm_sched_if #(
  parameter int WIDTH = 32
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [WIDTH-1:0]   req0_mc;
  logic [WIDTH-1:0]   req0_mp;
  logic [WIDTH-1:0]   req1_mc;
  logic [WIDTH-1:0]   req1_mp;
  logic [1:0]         rsp_valid;
  logic [1:0]         rsp_ready;
  logic [2*WIDTH-1:0] rsp_prod;
  logic               rsp_err;
  logic [WIDTH-1:0]   spm_mc;
  logic [WIDTH-1:0]   spm_mp;
  logic               spm_start;
  logic               spm_done;
  logic [2*WIDTH-1:0] spm_prod;
  logic               busy;

  // Environment side: requesters plus the multiplier itself.
  modport master (
    output req_valid, req0_mc, req0_mp, req1_mc, req1_mp, rsp_ready,
    output spm_done, spm_prod,
    input  req_ready, rsp_valid, rsp_prod, rsp_err,
    input  spm_mc, spm_mp, spm_start, busy
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req0_mc, req0_mp, req1_mc, req1_mp, rsp_ready,
    input  spm_done, spm_prod,
    output req_ready, rsp_valid, rsp_prod, rsp_err,
    output spm_mc, spm_mp, spm_start, busy
  );
endinterface

`default_nettype wire

// File: rtl/spm_sched.sv
//==============================================================================
// spm_sched: two-requester round-robin scheduler with watchdog for the SPM. rev 1.0
//==============================================================================
`default_nettype none

module spm_sched #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 80
) (
  input  wire logic  clk,
  input  wire logic  rst,
  spm_sched_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          gnt;
  logic          last_grant;
  logic          sel;
  logic          take;
  logic          done_hit;
  logic          tmo_hit;
  logic [CW-1:0] cnt;

  always_comb begin
    sel      = (bus.req_valid == 2'b11) ? ~last_grant : bus.req_valid[1];
    // A handshake in the reset cycle would be lost, so never offer one.
    take     = (state == IDLE) && (bus.req_valid != 2'b00) && !rst;
    done_hit = (state == RUN) && bus.spm_done;
    tmo_hit  = (state == RUN) && !bus.spm_done && (cnt == CW'(TIMEOUT - 1));

    state_nx      = state;
    bus.req_ready = 2'b00;
    bus.rsp_valid = 2'b00;
    bus.spm_start = 1'b0;
    bus.busy      = (state != IDLE);

    case (state)
      IDLE: begin
        if (take) begin
          bus.req_ready = {sel, ~sel};
          state_nx      = RUN;
        end
      end
      RUN: begin
        bus.spm_start = 1'b1;
        if (done_hit || tmo_hit) begin
          state_nx = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid = {gnt, ~gnt};
        if (bus.rsp_ready[gnt]) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      gnt          <= 1'b0;
      last_grant   <= 1'b1;
      cnt          <= '0;
      bus.spm_mc   <= '0;
      bus.spm_mp   <= '0;
      bus.rsp_prod <= '0;
      bus.rsp_err  <= 1'b0;
    end else begin
      state <= state_nx;
      if (take) begin
        gnt        <= sel;
        last_grant <= sel;
        cnt        <= '0;
        bus.spm_mc <= sel ? bus.req1_mc : bus.req0_mc;
        bus.spm_mp <= sel ? bus.req1_mp : bus.req0_mp;
      end
      if (state == RUN) begin
        cnt <= cnt + CW'(1);
      end
      if (done_hit) begin
        bus.rsp_prod <= (2*WIDTH)'(bus.spm_prod);
        bus.rsp_err  <= 1'b0;
      end else if (tmo_hit) begin
        bus.rsp_prod <= '0;
        bus.rsp_err  <= 1'b1;
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_spm_sched.sv
//==============================================================================
// tb_spm_sched: randomized self-checking bench for spm_sched with an SPM model. rev 1.0
//==============================================================================
`default_nettype none

module tb_spm_sched;
  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 80;
  localparam int P       = 2 * WIDTH;
  localparam int HANG    = 100000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spm_sched_if #(.WIDTH(WIDTH)) bus ();

  spm_sched #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int         total      = 0;
  int         bad        = 0;
  int         spm_lat    = HANG;
  int         run_cnt    = 0;
  logic       junk       = 1'b0;
  logic [P-1:0] junk_prod = '0;
  logic       model_last = 1'b1;

  // SPM model: done arrives after spm_lat completed start-high cycles;
  // junk done/product pulses while idle must be ignored by the scheduler.
  always @(posedge clk) run_cnt <= bus.spm_start ? run_cnt + 1 : 0;
  assign bus.spm_done = bus.spm_start ? (run_cnt == spm_lat) : junk;
  assign bus.spm_prod = bus.spm_start ? P'(bus.spm_mc) * P'(bus.spm_mp) : junk_prod;

  function automatic logic pick(input logic [1:0] v);
    return (v == 2'b11) ? ~model_last : v[1];
  endfunction

  function automatic logic [P-1:0] mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return P'(a) * P'(b);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_last = 1'b1;
  endtask

  task automatic handshake(output int g, output logic [1:0] rdy, output bit ok);
    g = 0; rdy = 2'b00; ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (bus.req_ready !== 2'b00) begin
        rdy = bus.req_ready; g = bus.req_ready[1] ? 1 : 0; ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic collect(input int g, input int hold, output logic [P-1:0] prod,
                         output logic err, output logic [1:0] vld, output int starts,
                         output bit stable, output bit idle_after, output bit ok);
    prod = '0; err = 1'b0; vld = 2'b00; starts = 0;
    stable = 1'b1; idle_after = 1'b0; ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (bus.rsp_valid !== 2'b00) begin
        ok = 1'b1;
        break;
      end
      if (bus.spm_start === 1'b1) starts++;
      @(negedge clk);
    end
    if (!ok) return;
    vld = bus.rsp_valid; prod = bus.rsp_prod; err = bus.rsp_err;
    for (int k = 0; k < hold; k++) begin
      bus.rsp_ready = (g == 0) ? 2'b10 : 2'b01;
      @(negedge clk); #1;
      if (bus.rsp_valid !== vld || bus.rsp_prod !== prod || bus.rsp_err !== err ||
          bus.req_ready !== 2'b00) stable = 1'b0;
    end
    bus.rsp_ready = (g == 0) ? 2'b01 : 2'b10;
    @(negedge clk);
    idle_after = (bus.busy === 1'b0) && (bus.rsp_valid === 2'b00);
    bus.rsp_ready = 2'b00;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b00 || bus.spm_start !== 1'b0 ||
        bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctl: ready=%b valid=%b start=%b busy=%b, want all 0",
               bus.req_ready, bus.rsp_valid, bus.spm_start, bus.busy);
    end
    total++;
    if (bus.rsp_prod !== '0 || bus.rsp_err !== 1'b0 || bus.spm_mc !== '0 || bus.spm_mp !== '0) begin
      bad++;
      $display("FAIL reset_data: prod=%h err=%b mc=%h mp=%h, want all 0",
               bus.rsp_prod, bus.rsp_err, bus.spm_mc, bus.spm_mp);
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    int g, ns; logic [1:0] rdy, vl; bit ok, st, ia; logic [P-1:0] pr; logic er;
    spm_lat = 2 * WIDTH;
    bus.req0_mc = 3; bus.req0_mp = 5; bus.req_valid = 2'b01;
    handshake(g, rdy, ok);
    total++;
    if (!ok || rdy !== 2'b01) begin
      bad++; $display("FAIL t1_grant: ready=%b ok=%0d, want 01", rdy, ok);
    end
    model_last = 1'b0;
    #1;
    total++;
    if (bus.req_ready !== 2'b00 || bus.spm_start !== 1'b1) begin
      bad++; $display("FAIL t1_pulse: ready=%b start=%b, want 00/1", bus.req_ready, bus.spm_start);
    end
    bus.req_valid = 2'b00;
    collect(0, 0, pr, er, vl, ns, st, ia, ok);
    total++;
    if (!ok || vl !== 2'b01 || pr !== 64'd15 || er !== 1'b0) begin
      bad++; $display("FAIL t1_result: valid=%b prod=%0d err=%b, want 01/15/0", vl, pr, er);
    end
    total++;
    if (ns !== 2 * WIDTH + 1) begin
      bad++; $display("FAIL t1_starts: %0d start cycles, want %0d", ns, 2 * WIDTH + 1);
    end
  endtask

  task automatic test_contention();
    int g, ns; logic [1:0] rdy, vl; bit ok, st, ia; logic [P-1:0] pr; logic er;
    logic [WIDTH-1:0] a, b;
    do_reset();
    bus.req0_mc = $urandom; bus.req0_mp = $urandom;
    bus.req1_mc = $urandom; bus.req1_mp = $urandom;
    bus.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      spm_lat = $urandom_range(0, 40);
      handshake(g, rdy, ok);
      total++;
      if (!ok || g !== (k & 1)) begin
        bad++; $display("FAIL t2_grant%0d: grant=%0d ok=%0d, want %0d", k, g, ok, k & 1);
      end
      model_last = logic'(k & 1);
      a = (k & 1) ? bus.req1_mc : bus.req0_mc;
      b = (k & 1) ? bus.req1_mp : bus.req0_mp;
      if (k & 1) begin bus.req1_mc = $urandom; bus.req1_mp = $urandom; end
      else begin bus.req0_mc = $urandom; bus.req0_mp = $urandom; end
      collect(k & 1, 0, pr, er, vl, ns, st, ia, ok);
      total++;
      if (!ok || pr !== mul(a, b) || er !== 1'b0) begin
        bad++; $display("FAIL t2_prod%0d: prod=%h err=%b, want %h/0", k, pr, er, mul(a, b));
      end
    end
    bus.req_valid = 2'b00;
  endtask

  task automatic test_backpressure();
    int g, ns; logic [1:0] rdy, vl; bit ok, st, ia; logic [P-1:0] pr; logic er;
    spm_lat = 10;
    bus.req0_mc = 32'h1234_5678; bus.req0_mp = 32'h0000_0100; bus.req_valid = 2'b01;
    handshake(g, rdy, ok);
    model_last = 1'b0;
    bus.req1_mc = 32'h0000_0007; bus.req1_mp = 32'h0000_0009; bus.req_valid = 2'b10;
    collect(0, 20, pr, er, vl, ns, st, ia, ok);
    total++;
    if (!ok || !st || pr !== 64'h12_3456_7800) begin
      bad++; $display("FAIL t3_stable: ok=%0d stable=%0d prod=%h, want 1/1/1234567800", ok, st, pr);
    end
    total++;
    if (!ia) begin
      bad++; $display("FAIL t3_idle: idle_after=%0d, want 1", ia);
    end
    handshake(g, rdy, ok);
    total++;
    if (!ok || rdy !== 2'b10) begin
      bad++; $display("FAIL t3_next: ready=%b, want 10", rdy);
    end
    model_last = 1'b1;
    bus.req_valid = 2'b00;
    collect(1, 0, pr, er, vl, ns, st, ia, ok);
    total++;
    if (!ok || pr !== 64'd63 || vl !== 2'b10) begin
      bad++; $display("FAIL t3_prod: prod=%0d valid=%b, want 63/10", pr, vl);
    end
  endtask

  task automatic test_timeout();
    int g, ns; logic [1:0] rdy, vl; bit ok, st, ia; logic [P-1:0] pr; logic er;
    spm_lat = HANG;
    bus.req1_mc = 32'hDEAD_BEEF; bus.req1_mp = 32'h0000_0003; bus.req_valid = 2'b10;
    handshake(g, rdy, ok);
    model_last = 1'b1;
    bus.req_valid = 2'b00;
    collect(1, 0, pr, er, vl, ns, st, ia, ok);
    total++;
    if (!ok || ns !== TIMEOUT) begin
      bad++; $display("FAIL t4_starts: %0d start cycles ok=%0d, want %0d", ns, ok, TIMEOUT);
    end
    total++;
    if (er !== 1'b1 || pr !== '0 || vl !== 2'b10) begin
      bad++; $display("FAIL t4_err: err=%b prod=%h valid=%b, want 1/0/10", er, pr, vl);
    end
    spm_lat = 7;
    bus.req0_mc = 32'd1000; bus.req0_mp = 32'd1000; bus.req_valid = 2'b01;
    handshake(g, rdy, ok);
    model_last = 1'b0;
    bus.req_valid = 2'b00;
    collect(0, 0, pr, er, vl, ns, st, ia, ok);
    total++;
    if (!ok || er !== 1'b0 || pr !== 64'd1000000) begin
      bad++; $display("FAIL t4_recover: err=%b prod=%0d, want 0/1000000", er, pr);
    end
  endtask

  task automatic test_edge();
    int g, ns; logic [1:0] rdy, vl; bit ok, st, ia; logic [P-1:0] pr; logic er;
    int lats [3];
    lats[0] = 2 * WIDTH + 1; lats[1] = TIMEOUT - 1; lats[2] = TIMEOUT;
    for (int k = 0; k < 3; k++) begin
      spm_lat = lats[k];
      bus.req0_mc = 32'hFFFF_FFFF; bus.req0_mp = 32'hFFFF_FFFF; bus.req_valid = 2'b01;
      handshake(g, rdy, ok);
      model_last = 1'b0;
      bus.req_valid = 2'b00;
      collect(0, 0, pr, er, vl, ns, st, ia, ok);
      total++;
      if (k < 2) begin
        if (!ok || er !== 1'b0 || pr !== 64'hFFFF_FFFE_0000_0001) begin
          bad++; $display("FAIL t5_max%0d: err=%b prod=%h, want 0/fffffffe00000001", k, er, pr);
        end
      end else begin
        if (!ok || er !== 1'b1 || pr !== '0) begin
          bad++; $display("FAIL t5_late: err=%b prod=%h, want 1/0", er, pr);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int g, ns; logic [1:0] rdy, vl; bit ok, st, ia, quiet; logic [P-1:0] pr; logic er;
    spm_lat = HANG;
    bus.req0_mc = 32'h0000_ABCD; bus.req0_mp = 32'h0000_0011; bus.req_valid = 2'b01;
    handshake(g, rdy, ok);
    bus.req_valid = 2'b00;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    total++;
    if (bus.spm_start !== 1'b0 || bus.busy !== 1'b0 || bus.rsp_valid !== 2'b00 ||
        bus.req_ready !== 2'b00 || bus.rsp_err !== 1'b0) begin
      bad++; $display("FAIL t6_ctl: start=%b busy=%b valid=%b ready=%b err=%b, want all 0",
                      bus.spm_start, bus.busy, bus.rsp_valid, bus.req_ready, bus.rsp_err);
    end
    total++;
    if (bus.spm_mc !== '0 || bus.spm_mp !== '0 || bus.rsp_prod !== '0) begin
      bad++; $display("FAIL t6_data: mc=%h mp=%h prod=%h, want all 0",
                      bus.spm_mc, bus.spm_mp, bus.rsp_prod);
    end
    rst = 1'b0;
    model_last = 1'b1;
    quiet = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b0) quiet = 1'b0;
    end
    total++;
    if (!quiet) begin
      bad++; $display("FAIL t6_quiet: response or busy seen after reset, want none");
    end
    @(negedge clk);
    spm_lat = 20;
    bus.req_valid = 2'b01;
    handshake(g, rdy, ok);
    model_last = 1'b0;
    bus.req_valid = 2'b00;
    collect(0, 0, pr, er, vl, ns, st, ia, ok);
    total++;
    if (!ok || er !== 1'b0 || pr !== mul(32'h0000_ABCD, 32'h0000_0011)) begin
      bad++; $display("FAIL t6_after: err=%b prod=%h, want 0/%h", er, pr,
                      mul(32'h0000_ABCD, 32'h0000_0011));
    end
  endtask

  task automatic test_random();
    int g, ns, exp_ns, lat, r, hold; logic [1:0] rdy, vl, v; bit ok, st, ia;
    logic [P-1:0] pr, exp_pr; logic er, exp_er, eg;
    for (int n = 0; n < 40; n++) begin
      v = 2'($urandom_range(1, 3));
      bus.req0_mc = $urandom; bus.req0_mp = $urandom;
      bus.req1_mc = $urandom; bus.req1_mp = $urandom;
      r = $urandom_range(0, 9);
      lat = (r == 0) ? HANG : (r == 1) ? TIMEOUT - 1 : $urandom_range(0, 2 * WIDTH + 2);
      spm_lat = lat;
      junk = 1'($urandom_range(0, 1));
      junk_prod = {$urandom, $urandom};
      hold = $urandom_range(0, 3);
      eg = pick(v);
      exp_er = (lat >= TIMEOUT);
      exp_ns = exp_er ? TIMEOUT : lat + 1;
      exp_pr = exp_er ? '0 : (eg ? mul(bus.req1_mc, bus.req1_mp) : mul(bus.req0_mc, bus.req0_mp));
      bus.req_valid = v;
      handshake(g, rdy, ok);
      model_last = eg;
      bus.req_valid = 2'b00;
      total++;
      if (!ok || g !== int'(eg)) begin
        bad++; $display("FAIL rnd_grant%0d: v=%b grant=%0d ok=%0d, want %0d", n, v, g, ok, eg);
      end
      collect(int'(eg), hold, pr, er, vl, ns, st, ia, ok);
      total++;
      if (!ok || pr !== exp_pr || er !== exp_er || vl !== {eg, ~eg}) begin
        bad++; $display("FAIL rnd_rsp%0d: prod=%h err=%b valid=%b, want %h/%b/%b",
                        n, pr, er, vl, exp_pr, exp_er, {eg, ~eg});
      end
      total++;
      if (ns !== exp_ns || !st || !ia) begin
        bad++; $display("FAIL rnd_timing%0d: starts=%0d stable=%0d idle=%0d, want %0d/1/1",
                        n, ns, st, ia, exp_ns);
      end
    end
    junk = 1'b0;
  endtask

  initial begin
    bus.req_valid = 2'b00; bus.rsp_ready = 2'b00;
    bus.req0_mc = '0; bus.req0_mp = '0; bus.req1_mc = '0; bus.req1_mp = '0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_timeout();
    test_edge();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
